// File: rtl/gold_seq_pkg.sv
// Shared constants and helpers for the 38.211 Gold-sequence generator.
package gold_seq_pkg;

  localparam int unsigned NC     = 1600;
  localparam int unsigned LFSR_N = 31;

  // Feedback taps: x1(n+31) = x1(n+3)^x1(n), x2(n+31) = x2(n+3)^x2(n+2)^x2(n+1)^x2(n)
  localparam logic [LFSR_N-1:0] X1_TAPS = 31'h0000_0009;
  localparam logic [LFSR_N-1:0] X2_TAPS = 31'h0000_000F;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WARMUP = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;

  // PBCH DMRS c_init; the largest value (0x3F0203) fits comfortably in 31 bits.
  function automatic logic [LFSR_N-1:0] pbch_c_init(input logic [9:0] n_id,
                                                    input logic [2:0] ibar);
    logic [LFSR_N-1:0] ib;
    logic [LFSR_N-1:0] nq;
    ib = LFSR_N'(ibar) + 31'd1;
    nq = LFSR_N'(n_id[9:2]) + 31'd1;
    return ((ib * nq) << 11) + (ib << 6) + LFSR_N'(n_id[1:0]);
  endfunction

endpackage

// File: rtl/gold_lfsr_step.sv
// Advances the x1/x2 LFSR pair by STEP positions and emits the STEP output
// bits c at the advanced position (so they line up with the new state).
module gold_lfsr_step
  import gold_seq_pkg::*;
#(
  parameter int unsigned STEP = 2
) (
  input  logic [LFSR_N-1:0] x1_i,
  input  logic [LFSR_N-1:0] x2_i,
  output logic [LFSR_N-1:0] x1_o,
  output logic [LFSR_N-1:0] x2_o,
  output logic [STEP-1:0]   c_o
);

  logic [LFSR_N-1:0] x1_v;
  logic [LFSR_N-1:0] x2_v;

  // Bit 0 of each register is the oldest sample x(n); new bits enter at the top.
  always_comb begin
    x1_v = x1_i;
    x2_v = x2_i;
    c_o  = '0;
    for (int j = 0; j < STEP; j++) begin
      x1_v = {^(x1_v & X1_TAPS), x1_v[LFSR_N-1:1]};
      x2_v = {^(x2_v & X2_TAPS), x2_v[LFSR_N-1:1]};
    end
    x1_o = x1_v;
    x2_o = x2_v;
    for (int j = 0; j < STEP; j++) begin
      c_o[j] = x1_v[0] ^ x2_v[0];
      x1_v   = {^(x1_v & X1_TAPS), x1_v[LFSR_N-1:1]};
      x2_v   = {^(x2_v & X2_TAPS), x2_v[LFSR_N-1:1]};
    end
  end

endmodule

// File: rtl/gold_seq_gen.sv
// Gold-sequence generator: c(n) = x1(n+1600) ^ x2(n+1600), OUT_W bits per beat
// on an AXI-stream output with backpressure and tlast.
module gold_seq_gen
  import gold_seq_pkg::*;
#(
  parameter int unsigned OUT_W   = 2,
  parameter int unsigned MAX_LEN = 288,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              mode_i,
  input  logic [9:0]        N_id_i,
  input  logic [2:0]        ibar_SSB_i,
  input  logic [30:0]       c_init_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              busy_o,
  output logic [OUT_W-1:0]  m_axis_out_tdata,
  output logic              m_axis_out_tvalid,
  input  logic              m_axis_out_tready,
  output logic              m_axis_out_tlast
);

  localparam int unsigned WARM_CYC  = NC / OUT_W;
  localparam int unsigned WCNT_W    = $clog2(WARM_CYC);
  localparam int unsigned MAX_BEATS = MAX_LEN / OUT_W;
  localparam int unsigned BEAT_W    = $clog2(MAX_BEATS + 1);
  localparam int unsigned OUT_SH    = $clog2(OUT_W);

  logic [1:0]        state_q,  state_d;
  logic [WCNT_W-1:0] wcnt_q,   wcnt_d;
  logic [BEAT_W-1:0] rem_q,    rem_d;
  logic [LFSR_N-1:0] x1_q,     x1_d;
  logic [LFSR_N-1:0] x2_q,     x2_d;
  logic [OUT_W-1:0]  tdata_q,  tdata_d;
  logic              tvalid_q, tvalid_d;
  logic              tlast_q,  tlast_d;
  logic              busy_q,   busy_d;

  logic [LFSR_N-1:0] x1_adv;
  logic [LFSR_N-1:0] x2_adv;
  logic [OUT_W-1:0]  c_adv;
  logic              len_ok;
  logic              start_ok;
  logic [LFSR_N-1:0] c_init_sel;
  logic [BEAT_W-1:0] len_beats;

  gold_lfsr_step #(.STEP(OUT_W)) u_step (
    .x1_i (x1_q),
    .x2_i (x2_q),
    .x1_o (x1_adv),
    .x2_o (x2_adv),
    .c_o  (c_adv)
  );

  // Unusable lengths make start_i a no-op, even while a run is in progress.
  assign len_ok     = (len_i != '0) && ((len_i & LEN_W'(OUT_W - 1)) == '0)
                      && (len_i <= LEN_W'(MAX_LEN));
  assign start_ok   = start_i && len_ok;
  assign c_init_sel = mode_i ? c_init_i : pbch_c_init(N_id_i, ibar_SSB_i);
  assign len_beats  = BEAT_W'(len_i >> OUT_SH);

  always_comb begin : next_state
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    rem_d    = rem_q;
    x1_d     = x1_q;
    x2_d     = x2_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;

    case (state_q)
      ST_IDLE: ;
      ST_WARMUP: begin
        x1_d   = x1_adv;
        x2_d   = x2_adv;
        wcnt_d = wcnt_q + WCNT_W'(1);
        if (wcnt_q == WCNT_W'(WARM_CYC - 1)) begin
          state_d  = ST_STREAM;
          tvalid_d = 1'b1;
          tdata_d  = c_adv;
          tlast_d  = (rem_q == '0);
        end
      end
      ST_STREAM: begin
        // tdata_q always holds the bits at the current LFSR position.
        if (tvalid_q && m_axis_out_tready) begin
          if (tlast_q) begin
            state_d  = ST_IDLE;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
          end else begin
            x1_d    = x1_adv;
            x2_d    = x2_adv;
            tdata_d = c_adv;
            rem_d   = rem_q - BEAT_W'(1);
            tlast_d = (rem_q == BEAT_W'(1));
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (start_ok) begin
      state_d  = ST_WARMUP;
      wcnt_d   = '0;
      rem_d    = len_beats - BEAT_W'(1);
      x1_d     = LFSR_N'(1);
      x2_d     = c_init_sel;
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i) begin : regs
    if (reset_i) begin
      state_q  <= ST_IDLE;
      wcnt_q   <= '0;
      rem_q    <= '0;
      x1_q     <= LFSR_N'(1);
      x2_q     <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      rem_q    <= rem_d;
      x1_q     <= x1_d;
      x2_q     <= x2_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      busy_q   <= busy_d;
    end
  end

  assign busy_o            = busy_q;
  assign m_axis_out_tdata  = tdata_q;
  assign m_axis_out_tvalid = tvalid_q;
  assign m_axis_out_tlast  = tlast_q;

endmodule

// File: tb/tb_gold_seq_gen.sv
// Bench for gold_seq_gen: OUT_W=2 and OUT_W=8 instances checked against a
// direct evaluation of the x1/x2 recurrences.
module tb_gold_seq_gen;

  localparam int MAXL = 288;
  localparam int NCB  = 1600;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [9:0]  n_id = '0;
  logic [2:0]  ibar = '0;
  logic [30:0] c_init = '0;
  logic [8:0]  len = '0;

  logic       busy2, tvalid2, tlast2;
  logic       tready2 = 1'b1;
  logic [1:0] tdata2;
  logic       busy8, tvalid8, tlast8;
  logic       tready8 = 1'b1;
  logic [7:0] tdata8;

  int checks = 0;
  int passes = 0;
  bit sel8 = 1'b0;
  bit exp_c [0:MAXL-1];

  logic [7:0] c_tdata;
  logic       c_tvalid, c_tlast, c_busy;
  int         ow;

  always #5 clk = ~clk;

  gold_seq_gen #(.OUT_W(2), .MAX_LEN(288)) u_dut2 (
    .clk_i(clk), .reset_i(reset), .start_i(start), .mode_i(mode),
    .N_id_i(n_id), .ibar_SSB_i(ibar), .c_init_i(c_init), .len_i(len),
    .busy_o(busy2), .m_axis_out_tdata(tdata2), .m_axis_out_tvalid(tvalid2),
    .m_axis_out_tready(tready2), .m_axis_out_tlast(tlast2));

  gold_seq_gen #(.OUT_W(8), .MAX_LEN(288)) u_dut8 (
    .clk_i(clk), .reset_i(reset), .start_i(start), .mode_i(mode),
    .N_id_i(n_id), .ibar_SSB_i(ibar), .c_init_i(c_init), .len_i(len),
    .busy_o(busy8), .m_axis_out_tdata(tdata8), .m_axis_out_tvalid(tvalid8),
    .m_axis_out_tready(tready8), .m_axis_out_tlast(tlast8));

  always_comb begin
    if (sel8) begin
      c_tdata = tdata8; c_tvalid = tvalid8; c_tlast = tlast8; c_busy = busy8; ow = 8;
    end else begin
      c_tdata = {6'b0, tdata2}; c_tvalid = tvalid2; c_tlast = tlast2; c_busy = busy2; ow = 2;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: run both recurrences from their initial values, take c(n).
  task automatic build_model(input logic [30:0] ci);
    bit x1 [0:NCB+MAXL-1];
    bit x2 [0:NCB+MAXL-1];
    for (int i = 0; i < 31; i++) begin
      x1[i] = (i == 0);
      x2[i] = ci[i];
    end
    for (int n = 0; n + 31 < NCB + MAXL; n++) begin
      x1[n+31] = x1[n+3] ^ x1[n];
      x2[n+31] = x2[n+3] ^ x2[n+2] ^ x2[n+1] ^ x2[n];
    end
    for (int n = 0; n < MAXL; n++) exp_c[n] = x1[n+NCB] ^ x2[n+NCB];
  endtask

  function automatic logic [7:0] exp_beat(input int b, input int w);
    logic [7:0] r;
    r = '0;
    for (int k = 0; k < w; k++) r[k] = exp_c[w*b+k];
    return r;
  endfunction

  function automatic int pbch_ref(input int nid, input int ib);
    return 2048 * (ib + 1) * (nid / 4 + 1) + 64 * (ib + 1) + nid % 4;
  endfunction

  task automatic do_start(input bit m, input int nid, input int ib, input logic [30:0] ci,
                          input int ln, input string tag);
    mode = m; n_id = 10'(nid); ibar = 3'(ib); c_init = ci; len = 9'(ln);
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (c_busy !== 1'b1 || c_tvalid !== 1'b0 || c_tlast !== 1'b0)
      $display("FAIL %s start: busy=%0b tvalid=%0b tlast=%0b, expected busy=1 tvalid=0 tlast=0",
               tag, c_busy, c_tvalid, c_tlast);
    else passes++;
  endtask

  task automatic wait_first(input string tag);
    int n;
    n = 0;
    while (c_tvalid !== 1'b1 && n < NCB / ow + 10) begin
      tick();
      n++;
    end
    checks++;
    if (n !== NCB / ow)
      $display("FAIL %s latency: first tvalid %0d cycles after start edge, expected %0d",
               tag, n, NCB / ow);
    else passes++;
  endtask

  task automatic stream(input int nbeats, input int stop, input int ready_pct, input string tag);
    int idx, guard;
    bit rdy, exp_last;
    logic [7:0] exp_d;
    idx = 0;
    guard = 0;
    while (idx < stop && guard < 40 * nbeats + 100) begin
      rdy = ($urandom_range(99) < ready_pct);
      if (sel8) begin tready8 = rdy; tready2 = 1'b1; end
      else      begin tready2 = rdy; tready8 = 1'b1; end
      exp_d = exp_beat(idx, ow);
      exp_last = (idx == nbeats - 1);
      checks++;
      if (c_tvalid !== 1'b1 || c_tdata !== exp_d || c_tlast !== exp_last)
        $display("FAIL %s beat %0d: tvalid=%0b tdata=%h tlast=%0b, expected tvalid=1 tdata=%h tlast=%0b",
                 tag, idx, c_tvalid, c_tdata, c_tlast, exp_d, exp_last);
      else passes++;
      tick();
      if (rdy) idx++;
      guard++;
    end
    tready2 = 1'b1;
    tready8 = 1'b1;
    if (idx < stop) begin
      checks++;
      $display("FAIL %s timeout: %0d beats accepted, expected %0d", tag, idx, stop);
    end
  endtask

  task automatic check_idle(input string tag);
    checks++;
    if (c_tvalid !== 1'b0 || c_busy !== 1'b0 || c_tlast !== 1'b0)
      $display("FAIL %s idle: tvalid=%0b busy=%0b tlast=%0b, expected all 0",
               tag, c_tvalid, c_busy, c_tlast);
    else passes++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    checks++;
    if ({busy2, tvalid2, tlast2, tdata2} !== 5'b0)
      $display("FAIL reset2: busy=%0b tvalid=%0b tlast=%0b tdata=%h, expected 0", busy2, tvalid2, tlast2, tdata2);
    else passes++;
    checks++;
    if ({busy8, tvalid8, tlast8, tdata8} !== 11'b0)
      $display("FAIL reset8: busy=%0b tvalid=%0b tlast=%0b tdata=%h, expected 0", busy8, tvalid8, tlast8, tdata8);
    else passes++;
  endtask

  task automatic test_pbch(input int nid, input int ib, input logic [30:0] ci, input string tag);
    sel8 = 1'b0;
    build_model(ci);
    do_start(1'b0, nid, ib, 31'h0, 288, tag);
    wait_first(tag);
    stream(144, 144, 100, tag);
    check_idle(tag);
  endtask

  task automatic test_stall_x8();
    sel8 = 1'b1;
    build_model(31'h0);
    do_start(1'b1, 0, 0, 31'h0, 64, "stall8");
    wait_first("stall8");
    stream(8, 8, 50, "stall8");
    check_idle("stall8");
    sel8 = 1'b0;
    repeat (40) tick();
  endtask

  task automatic test_abort();
    int a, b;
    sel8 = 1'b0;
    a = $urandom_range(1007); b = $urandom_range(7);
    build_model(31'(pbch_ref(a, b)));
    do_start(1'b0, a, b, 31'h0, 288, "abort_a");
    wait_first("abort_a");
    stream(144, 20, 100, "abort_a");
    a = (a + 1 + $urandom_range(500)) % 1008;
    build_model(31'(pbch_ref(a, b)));
    do_start(1'b0, a, b, 31'h0, 288, "abort_b");
    wait_first("abort_b");
    stream(144, 144, 100, "abort_b");
    check_idle("abort_b");
  endtask

  task automatic test_reset_mid();
    sel8 = 1'b0;
    build_model(31'h840);
    do_start(1'b0, 0, 0, 31'h0, 288, "rst_warm");
    repeat (100) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    check_idle("rst_warm");
    do_start(1'b0, 0, 0, 31'h0, 288, "rst_strm");
    wait_first("rst_strm");
    stream(144, 10, 100, "rst_strm");
    reset = 1'b1; tick(); reset = 1'b0;
    check_idle("rst_strm");
    test_pbch(0, 0, 31'h840, "rst_again");
  endtask

  task automatic test_bad_len();
    int lens [2] = '{0, 3};
    sel8 = 1'b0;
    foreach (lens[i]) begin
      len = 9'(lens[i]); mode = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      repeat (5) tick();
      checks++;
      if (busy2 !== 1'b0 || tvalid2 !== 1'b0)
        $display("FAIL badlen %0d: busy=%0b tvalid=%0b, expected 0 0", lens[i], busy2, tvalid2);
      else passes++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_d;
    sel8 = 1'b0;
    build_model(31'h1234567);
    do_start(1'b1, 0, 0, 31'h1234567, 8, "b2b_a");
    wait_first("b2b_a");
    stream(4, 3, 100, "b2b_a");
    exp_d = exp_beat(3, 2);
    checks++;
    if (tvalid2 !== 1'b1 || {6'b0, tdata2} !== exp_d || tlast2 !== 1'b1)
      $display("FAIL b2b_a last beat: tvalid=%0b tdata=%h tlast=%0b, expected 1 %h 1",
               tvalid2, tdata2, tlast2, exp_d);
    else passes++;
    tready2 = 1'b1;
    build_model(31'h7654321);
    do_start(1'b1, 0, 0, 31'h7654321, 16, "b2b_b");
    wait_first("b2b_b");
    stream(8, 8, 100, "b2b_b");
    check_idle("b2b_b");
  endtask

  task automatic test_random();
    bit m;
    int nid, ib, ln;
    logic [30:0] ci, ce;
    sel8 = 1'b0;
    for (int r = 0; r < 3; r++) begin
      m = 1'($urandom_range(1));
      nid = $urandom_range(1007); ib = $urandom_range(7);
      ci = 31'($urandom);
      ln = 2 * $urandom_range(1, 144);
      ce = m ? ci : 31'(pbch_ref(nid, ib));
      build_model(ce);
      do_start(m, nid, ib, ci, ln, "rand");
      wait_first("rand");
      stream(ln / 2, ln / 2, 70, "rand");
      check_idle("rand");
    end
  endtask

  initial begin
    test_reset();
    test_pbch(0, 0, 31'h840, "pbch_min");
    test_pbch(1007, 7, 31'h3F0203, "pbch_max");
    test_stall_x8();
    test_abort();
    test_reset_mid();
    test_bad_len();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
